// File: rtl/fetch_if.sv
// fetch_if: groups the fetch unit's ROM bus, instruction handshake and
// redirect signals.
//   master : the fetch unit. It drives rom_addr/rom_ena/rom_read and
//            ir_valid/ir_opcode/ir_operand. It samples rom_data, ir_ready,
//            jmp_valid and jmp_addr.
//   slave  : the ROM and the decode/execute side, which sees the opposite
//            directions.
interface fetch_if;
  logic [5:0] rom_addr;
  logic       rom_ena;
  logic       rom_read;
  logic [7:0] rom_data;
  logic       ir_valid;
  logic       ir_ready;
  logic [1:0] ir_opcode;
  logic [5:0] ir_operand;
  logic       jmp_valid;
  logic [5:0] jmp_addr;

  modport master (
    output rom_addr, rom_ena, rom_read,
    input  rom_data,
    output ir_valid, ir_opcode, ir_operand,
    input  ir_ready,
    input  jmp_valid, jmp_addr
  );

  modport slave (
    input  rom_addr, rom_ena, rom_read,
    output rom_data,
    input  ir_valid, ir_opcode, ir_operand,
    output ir_ready,
    output jmp_valid, jmp_addr
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch initiator for the simpleCPU.
//
// This block owns the program counter. It walks the ROM one word at a time
// through the states ADDR and READ. It then presents the captured word to
// the decode/execute stage through a valid/ready handshake.
//
// Ports:
//   clk, rst   single rising-edge clock; synchronous active-high reset
//   start      pulse that leaves IDLE and starts fetching at pc
//   bus        fetch_if.master, which carries:
//                - the ROM strobes and data
//                - the ir handshake and ir fields
//                - the jump redirect request
//   pc         current fetch address
//   halted     high while in HALT
//
// PROG_LEN is the number of valid ROM words (1..64). Any fetch at
// pc >= PROG_LEN halts without a read strobe.
module fetch_unit #(
  parameter int PROG_LEN = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  fetch_if.master    bus,
  output logic [5:0] pc,
  output logic       halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_READ,
    S_VALID,
    S_HALT
  } state_t;

  // PROG_LEN can be 64, so the compare is done one bit wider than pc.
  localparam logic [6:0] PROG_END = 7'(PROG_LEN);

  state_t     state;
  state_t     state_nxt;
  logic [5:0] pc_nxt;
  logic [7:0] ir;
  logic       ir_load;
  logic       past_end;

  assign past_end = {1'b0, pc} >= PROG_END;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ir_load   = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (start) state_nxt = S_ADDR;
      end
      S_ADDR: begin
        if (past_end) state_nxt = S_HALT;
        else          state_nxt = S_READ;
      end
      S_READ: begin
        ir_load   = 1'b1;
        state_nxt = S_VALID;
      end
      S_VALID: begin
        if (bus.ir_ready) begin
          if (ir[7:6] == 2'b00) begin
            state_nxt = S_HALT;
          end else begin
            pc_nxt    = pc + 6'd1;
            state_nxt = S_ADDR;
          end
        end
      end
      S_HALT: begin
        // Only a jump or a reset leaves HALT; start is ignored here.
        state_nxt = S_HALT;
      end
      default: state_nxt = S_IDLE;
    endcase

    // A redirect outranks normal sequencing in every state except IDLE.
    // It discards an in-flight capture and swallows a handshake that
    // lands in the same cycle, so pc does not increment.
    if (state != S_IDLE && bus.jmp_valid) begin
      pc_nxt    = bus.jmp_addr;
      ir_load   = 1'b0;
      state_nxt = S_ADDR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      pc    <= 6'd0;
      ir    <= 8'd0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      // rom_data is only trusted at the edge that ends READ.
      if (ir_load) ir <= bus.rom_data;
    end
  end

  // All strobes and flags are decoded from the registered state only.
  assign bus.rom_addr   = pc;
  assign bus.rom_ena    = (state == S_ADDR) || (state == S_READ);
  assign bus.rom_read   = (state == S_READ);
  assign bus.ir_valid   = (state == S_VALID);
  assign bus.ir_opcode  = ir[7:6];
  assign bus.ir_operand = ir[5:0];
  assign halted         = (state == S_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [5:0] pc;
  logic       halted;
  logic [7:0] rom [64];
  int         checks   = 0;
  int         failures = 0;

  fetch_if bus();

  fetch_unit #(.PROG_LEN(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .bus    (bus),
    .pc     (pc),
    .halted (halted)
  );

  always #5 clk = ~clk;

  // Level-sensitive ROM model: it drives data only while read && ena.
  assign bus.rom_data = (bus.rom_read && bus.rom_ena) ? rom[bus.rom_addr] : 8'hxx;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic e_ena, input logic e_read,
                      input logic e_valid, input logic e_halt, input logic [5:0] e_pc);
    chk({tag, "_ena"},   32'(bus.rom_ena),  32'(e_ena));
    chk({tag, "_read"},  32'(bus.rom_read), 32'(e_read));
    chk({tag, "_valid"}, 32'(bus.ir_valid), 32'(e_valid));
    chk({tag, "_halt"},  32'(halted),       32'(e_halt));
    chk({tag, "_pc"},    32'(pc),           32'(e_pc));
    chk({tag, "_addr"},  32'(bus.rom_addr), 32'(e_pc));
  endtask

  task automatic irchk(input string tag, input logic [7:0] e_ir);
    chk({tag, "_ir"}, 32'({bus.ir_opcode, bus.ir_operand}), 32'(e_ir));
  endtask

  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    bus.ir_ready  = 1'b0;
    bus.jmp_valid = 1'b0;
    bus.jmp_addr  = 6'd0;
    for (int i = 0; i < 64; i++) rom[i] = 8'h00;
    rom[0] = 8'h43; rom[1] = 8'h82; rom[2] = 8'h43; rom[3] = 8'h82;
    rom[4] = 8'hC3; rom[5] = 8'hC2; rom[6] = 8'hC3; rom[7] = 8'hC2;

    // Reset values
    tick(); tick();
    outs("reset", 0, 0, 0, 0, 6'd0);
    irchk("reset", 8'h00);
    rst = 1'b0;
    tick();
    outs("idle", 0, 0, 0, 0, 6'd0);

    // Start: word 0 with ir_ready high
    start = 1'b1;
    tick();
    start = 1'b0;
    bus.ir_ready = 1'b1;
    outs("w0_addr", 1, 0, 0, 0, 6'd0);
    tick(); outs("w0_read", 1, 1, 0, 0, 6'd0);
    tick(); outs("w0_valid", 0, 0, 1, 0, 6'd0); irchk("w0", 8'h43);
    tick(); outs("w1_addr", 1, 0, 0, 0, 6'd1);

    // Backpressure on word 1
    bus.ir_ready = 1'b0;
    tick(); outs("w1_read", 1, 1, 0, 0, 6'd1);
    tick(); outs("w1_valid", 0, 0, 1, 0, 6'd1); irchk("w1", 8'h82);
    for (int k = 0; k < 4; k++) begin
      tick(); outs("bp_hold", 0, 0, 1, 0, 6'd1); irchk("bp_hold", 8'h82);
    end
    bus.ir_ready = 1'b1;
    tick(); outs("bp_release", 1, 0, 0, 0, 6'd2);
    tick(); outs("w2_read", 1, 1, 0, 0, 6'd2);
    tick(); outs("w2_valid", 0, 0, 1, 0, 6'd2); irchk("w2", 8'h43);
    tick(); outs("w3_addr", 1, 0, 0, 0, 6'd3);
    tick(); outs("w3_read", 1, 1, 0, 0, 6'd3);

    // Jump during READ of word 3: the capture is discarded
    bus.jmp_valid = 1'b1;
    bus.jmp_addr  = 6'd0;
    tick();
    bus.jmp_valid = 1'b0;
    outs("jmp_read", 1, 0, 0, 0, 6'd0);
    tick(); outs("jr_read", 1, 1, 0, 0, 6'd0);
    tick(); outs("jr_valid", 0, 0, 1, 0, 6'd0); irchk("jr", 8'h43);

    // Jump concurrent with an accepted handshake: no increment
    bus.jmp_valid = 1'b1;
    bus.jmp_addr  = 6'd4;
    tick();
    bus.jmp_valid = 1'b0;
    outs("jmp_hs", 1, 0, 0, 0, 6'd4);

    // Words 4..7, then pc=8 halts on program length
    for (int i = 4; i < 8; i++) begin
      outs("seq_addr", 1, 0, 0, 0, 6'(i));
      tick(); outs("seq_read", 1, 1, 0, 0, 6'(i));
      tick(); outs("seq_valid", 0, 0, 1, 0, 6'(i)); irchk("seq", rom[i]);
      tick();
    end
    outs("end_addr", 1, 0, 0, 0, 6'd8);
    tick(); outs("end_halt", 0, 0, 0, 1, 6'd8);
    start = 1'b1;
    tick();
    start = 1'b0;
    outs("end_start", 0, 0, 0, 1, 6'd8);

    // HLT opcode at address 2
    rom[2] = 8'h00;
    bus.jmp_valid = 1'b1;
    bus.jmp_addr  = 6'd0;
    tick();
    bus.jmp_valid = 1'b0;
    outs("halt_jmp", 1, 0, 0, 0, 6'd0);
    for (int i = 0; i < 3; i++) begin
      outs("h_addr", 1, 0, 0, 0, 6'(i));
      tick(); outs("h_read", 1, 1, 0, 0, 6'(i));
      tick(); outs("h_valid", 0, 0, 1, 0, 6'(i)); irchk("h", rom[i]);
      tick();
    end
    outs("hlt_op", 0, 0, 0, 1, 6'd2);
    start = 1'b1;
    tick();
    start = 1'b0;
    outs("hlt_start", 0, 0, 0, 1, 6'd2);
    bus.jmp_valid = 1'b1;
    bus.jmp_addr  = 6'd5;
    tick();
    bus.jmp_valid = 1'b0;
    outs("resume", 1, 0, 0, 0, 6'd5);
    tick(); outs("r5_read", 1, 1, 0, 0, 6'd5);
    tick(); outs("r5_valid", 0, 0, 1, 0, 6'd5); irchk("r5", 8'hC2);
    tick(); outs("r6_addr", 1, 0, 0, 0, 6'd6);
    tick(); outs("r6_read", 1, 1, 0, 0, 6'd6);

    // Reset during READ
    rst = 1'b1;
    tick();
    outs("rst_read", 0, 0, 0, 0, 6'd0);
    irchk("rst_read", 8'h00);
    rst = 1'b0;
    tick(); outs("rst_idle", 0, 0, 0, 0, 6'd0);
    tick(); outs("rst_idle2", 0, 0, 0, 0, 6'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
